data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/mem_map_pkg.sv | 20 ++
 rtl/mmio_regs.sv | 73 +++++++
 rtl/data_mem_ctrl.sv | 92 +++++++++
 tb/tb_data_mem_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the data memory controller.
// Pure definitions: no logic, no latency.
// Holds the controller state encoding, the MMIO window base and register offsets.
package mem_map_pkg;

    localparam int unsigned    DEF_RAM_WORDS = 1024;
    localparam logic [31:0]    DEF_IO_BASE   = 32'h0000_1000;

    // Byte offsets of the MMIO registers inside the 256-byte window
    localparam logic [7:0]     OFF_LED    = 8'h00;
    localparam logic [7:0]     OFF_SW     = 8'h04;
    localparam logic [7:0]     OFF_CYCLE  = 8'h08;
    localparam logic [7:0]     OFF_STATUS = 8'h0C;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mmio_regs.sv
// MMIO register bank: LED, synchronized switches, free-running cycle counter, sticky error status.
// Reads are combinational from the word offset; writes and counter updates land on the next edge.
// No backpressure: every write presented with wr_en is accepted in the same cycle.
module mmio_regs
    import mem_map_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [5:0]  word_off,
    input  logic [7:0]  wdata_lo,
    input  logic        err_set,
    input  logic [7:0]  sw_in,
    output logic [31:0] rdata,
    output logic [7:0]  led_out
);

    logic [7:0]  led_q,   led_d;
    logic [7:0]  sw_s1_q, sw_s1_d;
    logic [7:0]  sw_s2_q, sw_s2_d;
    logic [31:0] cycle_q, cycle_d;
    logic        err_q,   err_d;

    // Next-state for every register; a same-edge set of the error flag beats a clear
    always_comb begin
        led_d   = led_q;
        sw_s1_d = sw_in;
        sw_s2_d = sw_s1_q;
        cycle_d = cycle_q + 32'd1;
        err_d   = err_q;
        if (wr_en && (word_off == OFF_LED[7:2])) begin
            led_d = wdata_lo;
        end
        if (wr_en && (word_off == OFF_STATUS[7:2]) && wdata_lo[0]) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    // Register update with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q   <= 8'h00;
            sw_s1_q <= 8'h00;
            sw_s2_q <= 8'h00;
            cycle_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            led_q   <= led_d;
            sw_s1_q <= sw_s1_d;
            sw_s2_q <= sw_s2_d;
            cycle_q <= cycle_d;
            err_q   <= err_d;
        end
    end

    // Read mux; unlisted offsets read as zero
    always_comb begin
        rdata = 32'h0;
        case (word_off)
            OFF_LED[7:2]:    rdata = {24'h0, led_q};
            OFF_SW[7:2]:     rdata = {24'h0, sw_s2_q};
            OFF_CYCLE[7:2]:  rdata = cycle_q;
            OFF_STATUS[7:2]: rdata = {31'h0, err_q};
            default:         rdata = 32'h0;
        endcase
    end

    assign led_out = led_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// CPU data-memory controller: decodes loads/stores to external RAM, MMIO registers or unmapped space.
// RAM loads take 2 cycles (one Stall cycle); RAM stores, MMIO and unmapped accesses take 1 cycle.
// Stall is the only backpressure: raised combinationally in the first cycle of a RAM load.
module data_mem_ctrl
    import mem_map_pkg::*;
#(
    parameter int unsigned RAM_WORDS = DEF_RAM_WORDS,
    parameter logic [31:0] IO_BASE   = DEF_IO_BASE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          MemRead,
    input  logic                          MemWrite,
    input  logic [31:0]                   Addr,
    input  logic [31:0]                   WriteData,
    output logic [31:0]                   ReadData,
    output logic                          Stall,
    output logic [$clog2(RAM_WORDS)-1:0]  ram_addr,
    output logic                          ram_we,
    output logic [31:0]                   ram_wdata,
    input  logic [31:0]                   ram_rdata,
    output logic [7:0]                    led_out,
    input  logic [7:0]                    sw_in
);

    localparam int unsigned AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    state_e      state_q, state_d;
    logic        ram_hit, io_hit, unmapped;
    logic        io_we, err_set;
    logic [31:0] io_rdata;

    assign ram_hit   = (Addr < RAM_BYTES);
    assign io_hit    = (Addr[31:8] == IO_BASE[31:8]);
    assign unmapped  = !ram_hit && !io_hit;
    assign ram_addr  = Addr[AW+1:2];
    assign ram_wdata = WriteData;

    // Access decode and load sequencing; a simultaneous read+write is handled as a write
    always_comb begin
        state_d  = ST_IDLE;
        Stall    = 1'b0;
        ReadData = 32'h0;
        ram_we   = 1'b0;
        io_we    = 1'b0;
        err_set  = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (MemRead && !MemWrite && ram_hit) begin
                        Stall   = 1'b1;
                        state_d = ST_RD_WAIT;
                    end else if (MemRead && !MemWrite && io_hit) begin
                        ReadData = io_rdata;
                    end
                    ram_we  = MemWrite && ram_hit;
                    io_we   = MemWrite && io_hit;
                    err_set = ((MemRead || MemWrite) && unmapped) || (MemRead && MemWrite);
                end
                ST_RD_WAIT: begin
                    // RAM data is now valid; the held MemRead does not start another load
                    ReadData = ram_rdata;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register; reset abandons any load in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    mmio_regs u_mmio (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (io_we),
        .word_off (Addr[7:2]),
        .wdata_lo (WriteData[7:0]),
        .err_set  (err_set),
        .sw_in    (sw_in),
        .rdata    (io_rdata),
        .led_out  (led_out)
    );

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
    import mem_map_pkg::*;

    localparam int RW = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] Addr, WriteData, ReadData;
    logic        Stall;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata, ram_rdata;
    logic [7:0]  led_out, sw_in;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.RAM_WORDS(RW), .IO_BASE(32'h0000_1000)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .led_out   (led_out),
        .sw_in     (sw_in)
    );

    // External synchronous RAM: one-cycle read latency
    logic [31:0] ram [RW];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    // Edge counting for the expected CYCLE value
    logic [31:0] edges = 32'h0;
    logic [31:0] base_edge = 32'h0;
    always @(posedge clk) begin
        edges <= edges + 32'd1;
        if (reset) base_edge <= edges + 32'd1;
    end

    // Reference model state
    logic [31:0] ref_mem [RW];
    logic [7:0]  ref_led;
    logic [7:0]  ref_sw;
    logic        ref_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] io_exp(input logic [31:0] a);
        case (a[7:2])
            6'd0:    return {24'h0, ref_led};
            6'd1:    return {24'h0, ref_sw};
            6'd2:    return edges - base_edge;
            6'd3:    return {31'h0, ref_err};
            default: return 32'h0;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_stall", Stall, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_led", led_out, 0);
        reset = 1'b0;
        ref_led = 8'h00; ref_err = 1'b0; ref_sw = 8'h00;
    endtask

    // One complete CPU access, checked against the model, then the model is updated
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        bit          is_ram, is_io, clr, set;
        logic [31:0] exp_rd;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd;
        #1;
        is_ram = (a < 32'(RW * 4));
        is_io  = (a[31:8] == 24'h000010);
        chk("led_out", led_out, ref_led);
        if (rd && !wr && is_ram) begin
            chk("ld_stall", Stall, 1);
            chk("ld_we", ram_we, 0);
            @(negedge clk);
            #1;
            chk("rdwait_stall", Stall, 0);
            chk("ld_data", ReadData, ref_mem[a[11:2]]);
        end else begin
            exp_rd = (rd && !wr && is_io) ? io_exp(a) : 32'h0;
            chk("stall", Stall, 0);
            chk("rdata", ReadData, exp_rd);
            chk("ram_we", ram_we, (wr && is_ram) ? 32'd1 : 32'd0);
            if (wr && is_ram) begin
                chk("ram_addr", ram_addr, a[11:2]);
                chk("ram_wdata", ram_wdata, wd);
                ref_mem[a[11:2]] = wd;
            end
            if (wr && is_io && a[7:2] == 6'd0) ref_led = wd[7:0];
            clr = wr && is_io && (a[7:2] == 6'd3) && wd[0];
            set = ((rd || wr) && !is_ram && !is_io) || (rd && wr);
            if (set)      ref_err = 1'b1;
            else if (clr) ref_err = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, wd, w;
        int          op;
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        Addr = 32'h0; WriteData = 32'h0; sw_in = 8'h00;
        do_reset();

        // Counter and status start at zero
        access(1, 0, 32'h1008, 0);
        access(1, 0, 32'h100C, 0);

        // Preload the RAM words used by the random phase
        for (int i = 0; i < 16; i++) access(0, 1, 32'(i * 4), $urandom);
        for (int i = 1020; i < 1024; i++) access(0, 1, 32'(i * 4), $urandom);

        // Store then load with one stall cycle
        access(0, 1, 32'h10, 32'hDEAD_BEEF);
        access(1, 0, 32'h10, 0);
        chk("ld_deadbeef", ReadData, 32'hDEAD_BEEF);

        // Address decode boundaries and ignored low bits
        access(1, 0, 32'h0000_0FFF, 0);
        access(1, 0, 32'h0000_0013, 0);

        // LED write and readback
        access(0, 1, 32'h1000, 32'h1A5);
        access(1, 0, 32'h1000, 0);
        chk("led_a5", led_out, 32'hA5);
        chk("led_rd_a5", ReadData, 32'hA5);

        // Switch synchronizer: old value until two edges have passed
        @(negedge clk);
        sw_in = 8'h3C; MemRead = 1'b1; MemWrite = 1'b0; Addr = 32'h1004;
        #1;
        chk("sw_edge0", ReadData, 0);
        @(negedge clk); #1;
        chk("sw_edge1", ReadData, 0);
        @(negedge clk); #1;
        chk("sw_edge2", ReadData, 32'h3C);
        ref_sw = 8'h3C;

        // Error flag: unmapped load, clear, read+write collision, set beats clear
        access(1, 0, 32'h8000_0000, 0);
        access(1, 0, 32'h100C, 0);
        access(0, 1, 32'h100C, 1);
        access(1, 0, 32'h100C, 0);
        access(1, 1, 32'h20, 32'h55);
        access(1, 0, 32'h100C, 0);
        access(1, 1, 32'h100C, 1);
        access(1, 0, 32'h100C, 0);
        access(0, 1, 32'h1100, 32'h1);
        access(1, 0, 32'h100C, 0);

        // Reset while a load is waiting for RAM data
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; Addr = 32'h10;
        #1;
        chk("pre_rst_stall", Stall, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_rdwait_stall", Stall, 0);
        chk("rst_rdwait_we", ram_we, 0);
        @(negedge clk);
        reset = 1'b0; Addr = 32'h1008;
        ref_led = 8'h00; ref_err = 1'b0; ref_sw = 8'h00;
        #1;
        chk("post_rst_cycle", ReadData, 0);
        chk("post_rst_stall", Stall, 0);
        chk("post_rst_led", led_out, 0);
        Addr = 32'h100C; #1;
        chk("post_rst_status", ReadData, 0);
        Addr = 32'h1000; #1;
        chk("post_rst_ledrd", ReadData, 0);
        MemRead = 1'b0;
        repeat (3) @(negedge clk);
        ref_sw = sw_in;

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 2))
                0: begin
                    w = $urandom_range(0, 19);
                    if (w >= 16) w = w + 32'd1004;
                    a = w * 4 + $urandom_range(0, 3);
                end
                1: a = ($urandom_range(0, 1) != 0) ? 32'h1000 + $urandom_range(0, 15)
                                                   : 32'h1000 + $urandom_range(0, 255);
                default: a = ($urandom_range(0, 1) != 0) ? 32'h1100 + $urandom_range(0, 32'hEF00)
                                                         : (32'h8000_0000 | $urandom);
            endcase
            wd = $urandom;
            op = $urandom_range(0, 9);
            if (op < 4)      access(1, 0, a, wd);
            else if (op < 8) access(0, 1, a, wd);
            else if (op < 9) access(1, 1, a, wd);
            else             access(0, 0, a, wd);
        end

        // Counter wrap
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; Addr = 32'h1008;
        force dut.u_mmio.cycle_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_mmio.cycle_q;
        chk("cyc_fffe", ReadData, 32'hFFFF_FFFE);
        @(negedge clk); #1;
        chk("cyc_ffff", ReadData, 32'hFFFF_FFFF);
        @(negedge clk); #1;
        chk("cyc_wrap", ReadData, 32'h0);
        MemRead = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
